// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready command in, SETUP/ACCESS transfer out,
// held response back. A programmable ACCESS timeout aborts transfers to a silent slave.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              timeout_hit;
    logic              psel_nxt, penable_nxt, pwrite_nxt, rsp_vld_nxt, rsp_err_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;

    // Held low while reset is asserted even though the state already reads IDLE.
    assign cmd_rdy     = (state == IDLE) && !prst;
    assign timeout_hit = TO_EN && (cnt == CNT_LAST);

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_vld) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        rsp_vld_nxt   = rsp_vld;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        cnt_nxt       = cnt;
        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    psel_nxt   = 1'b1;
                    pwrite_nxt = cmd_write;
                    paddr_nxt  = cmd_addr;
                    pwdata_nxt = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                cnt_nxt     = '0;
            end
            ACCESS: begin
                // A ready slave on the last permitted cycle wins over the timeout.
                if (pready) begin
                    rsp_vld_nxt   = 1'b1;
                    rsp_rdata_nxt = pwrite ? '0 : prdata;
                    rsp_err_nxt   = pslverr;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                end else if (timeout_hit) begin
                    rsp_vld_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_rdy) rsp_vld_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_vld   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            rsp_vld   <= rsp_vld_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            cnt       <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-schedule model predicts every output on every cycle,
// with directed transfers, a mid-transfer reset and randomized traffic.
module tb_apb_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              pclk = 1'b0;
    logic              prst = 1'b1;
    logic              cmd_vld = 1'b0, cmd_write = 1'b0, cmd_rdy;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_vld, rsp_rdy = 1'b0, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata = '0;
    logic              pready = 1'b0, pslverr = 1'b0;

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0, n_fail = 0;
    int edge_cnt = 0;
    always @(posedge pclk) edge_cnt <= edge_cnt + 1;

    // Transaction schedule: accept edge, number of ACCESS cycles, release edge.
    bit          have_txn = 1'b0;
    int          t_acc = 0, n_acc = 0, t_rel = 0, w_cyc = 0;
    logic        x_wr = 1'b0, x_err = 1'b0, sl_v = 1'b0;
    logic [31:0] x_addr = '0, x_wdata = '0, x_rdata = '0, rd_v = '0;
    logic        p_wr = 1'b0, p_err = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0, p_rdata = '0;

    int          psel_cnt = 0, pen_cnt = 0, rsp_cnt = 0, lat = 0;
    bit          seen = 1'b0;
    logic [31:0] cap_rd = '0;
    logic        cap_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    always @(negedge pclk) begin
        int k;
        logic e_psel, e_pen, e_rv, e_rdy, e_wr, e_err;
        logic [31:0] e_addr, e_wd, e_rd;
        if (prst) begin
            {e_psel, e_pen, e_rv, e_rdy, e_wr, e_err} = '0;
            e_addr = '0; e_wd = '0; e_rd = '0;
        end else if (!have_txn || edge_cnt < t_acc) begin
            {e_psel, e_pen, e_rv} = '0;
            e_rdy = 1'b1;
            e_wr = p_wr; e_addr = p_addr; e_wd = p_wdata; e_rd = p_rdata; e_err = p_err;
        end else begin
            k      = edge_cnt - t_acc;
            e_psel = (k <= n_acc);
            e_pen  = (k >= 1) && (k <= n_acc);
            e_rv   = (k >= n_acc + 1) && (edge_cnt < t_rel);
            e_rdy  = (edge_cnt >= t_rel);
            e_wr = x_wr; e_addr = x_addr; e_wd = x_wdata;
            e_rd   = (k >= n_acc + 1) ? x_rdata : p_rdata;
            e_err  = (k >= n_acc + 1) ? x_err : p_err;
        end
        chk("psel", 32'(psel), 32'(e_psel));
        chk("penable", 32'(penable), 32'(e_pen));
        chk("rsp_vld", 32'(rsp_vld), 32'(e_rv));
        chk("cmd_rdy", 32'(cmd_rdy), 32'(e_rdy));
        chk("pwrite", 32'(pwrite), 32'(e_wr));
        chk("paddr", paddr, e_addr);
        chk("pwdata", pwdata, e_wd);
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
    end

    always @(negedge pclk) begin
        if (!prst) begin
            if (psel) psel_cnt++;
            if (penable) pen_cnt++;
            if (rsp_vld) begin
                rsp_cnt++;
                if (!seen) begin
                    seen = 1'b1;
                    lat = edge_cnt - t_acc + 1;
                    cap_rd = rsp_rdata;
                    cap_err = rsp_err;
                end
            end
        end
    end

    // Drives inputs for the cycle ending at edge edge_cnt+1; junk wherever the DUT must ignore it.
    task automatic drive_inputs();
        int s, a;
        s = edge_cnt + 1;
        a = s - t_acc - 1;
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        rsp_rdy = 1'($urandom_range(0, 1));
        if (have_txn && a >= 1 && a <= n_acc) begin
            pready = 1'b0;
            if (w_cyc < TIMEOUT && a == w_cyc + 1) begin
                pready = 1'b1; prdata = rd_v; pslverr = sl_v;
            end
        end
        if (have_txn && s > t_acc + n_acc + 1 && s <= t_rel) rsp_rdy = (s == t_rel);
        if (have_txn && s > t_acc && s <= t_rel) begin
            cmd_vld   = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end
    endtask

    task automatic present(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int w, input int d, input logic sl, input logic [31:0] rd);
        if (have_txn) begin
            p_wr = x_wr; p_addr = x_addr; p_wdata = x_wdata; p_rdata = x_rdata; p_err = x_err;
        end
        w_cyc = w; sl_v = sl; rd_v = rd;
        n_acc   = (w < TIMEOUT) ? w + 1 : TIMEOUT;
        x_wr    = wr;
        x_addr  = addr;
        x_wdata = wr ? wd : 32'h0;
        x_err   = (w < TIMEOUT) ? sl : 1'b1;
        x_rdata = (w < TIMEOUT && !wr) ? rd : 32'h0;
        t_acc   = edge_cnt + 1;
        t_rel   = t_acc + n_acc + 1 + d + 1;
        have_txn = 1'b1;
        psel_cnt = 0; pen_cnt = 0; rsp_cnt = 0; seen = 1'b0;
        drive_inputs();
        cmd_vld = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    endtask

    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int w, input int d, input int gap, input logic sl,
                          input logic [31:0] rd);
        for (int i = 0; i < gap; i++) begin
            cmd_vld = 1'b0;
            drive_inputs();
            @(posedge pclk); #1;
        end
        present(wr, addr, wd, w, d, sl, rd);
        while (edge_cnt < t_rel) begin
            @(posedge pclk); #1;
            if (edge_cnt < t_rel) drive_inputs();
        end
        cmd_vld = 1'b0;
    endtask

    task automatic do_reset_mid();
        present(1'b0, 32'h50, 32'h0, 20, 0, 1'b0, 32'h0);
        while (edge_cnt < t_acc + 2) begin
            @(posedge pclk); #1;
            drive_inputs();
        end
        cmd_vld = 1'b0;
        chk("rst_pre_psel", 32'(psel), 32'h1);
        chk("rst_pre_penable", 32'(penable), 32'h1);
        #2;
        prst = 1'b1;
        have_txn = 1'b0;
        p_wr = 1'b0; p_addr = '0; p_wdata = '0; p_rdata = '0; p_err = 1'b0;
        #1;
        chk("rst_async_psel", 32'(psel), 32'h0);
        chk("rst_async_penable", 32'(penable), 32'h0);
        chk("rst_async_rsp_vld", 32'(rsp_vld), 32'h0);
        chk("rst_async_cmd_rdy", 32'(cmd_rdy), 32'h0);
        @(posedge pclk); #1;
        prst = 1'b0;
        #1;
        chk("rst_release_cmd_rdy", 32'(cmd_rdy), 32'h1);
        @(posedge pclk); #1;
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("reset_paddr", paddr, 32'h0);
        prst = 1'b0;

        do_txn(1'b1, 32'h4, 32'hA5, 0, 0, 1, 1'b0, 32'h0);
        chk("t1_latency", lat, 3);
        chk("t1_psel_cycles", psel_cnt, 2);
        chk("t1_penable_cycles", pen_cnt, 1);
        chk("t1_rdata", cap_rd, 32'h0);
        chk("t1_err", 32'(cap_err), 32'h0);
        chk("t1_pwdata", pwdata, 32'hA5);
        chk("t1_pwrite", 32'(pwrite), 32'h1);

        do_txn(1'b0, 32'h8, 32'h0, 2, 0, 1, 1'b0, 32'h1);
        chk("t2_latency", lat, 5);
        chk("t2_penable_cycles", pen_cnt, 3);
        chk("t2_rdata", cap_rd, 32'h1);
        chk("t2_err", 32'(cap_err), 32'h0);
        chk("t2_paddr", paddr, 32'h8);

        do_txn(1'b0, 32'h10, 32'h0, 0, 0, 0, 1'b1, 32'hDEAD_BEEF);
        chk("t3_err", 32'(cap_err), 32'h1);
        chk("t3_rdata", cap_rd, 32'hDEAD_BEEF);

        do_txn(1'b0, 32'h20, 32'h0, 20, 0, 0, 1'b0, 32'h55);
        chk("t4_timeout_penable_cycles", pen_cnt, 4);
        chk("t4_timeout_psel_cycles", psel_cnt, 5);
        chk("t4_timeout_latency", lat, 6);
        chk("t4_timeout_err", 32'(cap_err), 32'h1);
        chk("t4_timeout_rdata", cap_rd, 32'h0);

        do_txn(1'b0, 32'h24, 32'h0, 3, 0, 0, 1'b0, 32'h1234);
        chk("t4_last_penable_cycles", pen_cnt, 4);
        chk("t4_last_err", 32'(cap_err), 32'h0);
        chk("t4_last_rdata", cap_rd, 32'h1234);

        do_txn(1'b1, 32'h30, 32'h11, 0, 5, 0, 1'b0, 32'h0);
        chk("t5_hold_cycles", rsp_cnt, 6);
        do_txn(1'b1, 32'h34, 32'h22, 1, 0, 0, 1'b0, 32'h0);
        chk("t5_second_latency", lat, 4);

        do_reset_mid();
        do_txn(1'b1, 32'h40, 32'h77, 0, 0, 0, 1'b0, 32'h0);
        chk("t6_latency", lat, 3);
        chk("t6_err", 32'(cap_err), 32'h0);
        chk("t6_pwdata", pwdata, 32'h77);

        repeat (60)
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 3) == 0), $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
